pc_sequencer: RTL

Multi-cycle instruction sequencer that owns the 8-bit program counter.
- Runs each instruction through fetch, decode, ALU execute and next-PC resolve.
- Resolves the conditional branch, jump, jump-register and jump-and-link opcodes.
- Handshakes with instruction memory, the ALU and the register file (jr operand read, jal link write).
- Sits between the instruction memory and the execute datapath, replacing free-running PC increment.

---
 rtl/pc_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/decode/execute/resolve sequencer that owns
// the program counter and resolves branch, jump, jump-register and
// jump-and-link opcodes.
// Optional build macro: PC_SEQ_PERF_CNT_EN adds the taken_cnt and instr_cnt
// performance counter ports.
module pc_sequencer #(
  parameter int              PC_W        = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              ALU_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [31:0]     instr,
  output logic            alu_start,
  input  logic            alu_done,
  input  logic [31:0]     alu_result,
  output logic [4:0]      rf_rd_reg,
  input  logic [31:0]     rf_rd_data,
  output logic            link_we,
  output logic [31:0]     link_data,
  output logic [PC_W-1:0] pc,
`ifdef PC_SEQ_PERF_CNT_EN
  output logic [15:0]     taken_cnt,
  output logic [15:0]     instr_cnt,
`endif
  output logic [2:0]      state_dbg,
  output logic            halted,
  output logic            error
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_RESOLVE = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  localparam logic [5:0] OP_BNE_BACK = 6'b001110;
  localparam logic [5:0] OP_BNE_FWD  = 6'b001111;
  localparam logic [5:0] OP_BEQ_A    = 6'b010000;
  localparam logic [5:0] OP_BEQ_B    = 6'b010001;
  localparam logic [5:0] OP_BONE_A   = 6'b010010;
  localparam logic [5:0] OP_BONE_B   = 6'b010011;
  localparam logic [5:0] OP_J        = 6'b010100;
  localparam logic [5:0] OP_JR       = 6'b010101;
  localparam logic [5:0] OP_JAL      = 6'b010110;
  localparam logic [5:0] OP_HALT     = 6'b111111;

  localparam int TO_W = $clog2(ALU_TIMEOUT + 1);

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [5:0]      op_q, op_d;
  logic [4:0]      reg0_q, reg0_d;
  logic [PC_W-1:0] imm_q, imm_d;
  logic [31:0]     result_q, result_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] addr_pc;
  logic            is_jump;
  logic            unused_bits;

  // Bits of the instruction and register word that never reach the PC.
  assign unused_bits = ^{instr[20:16], instr[15:PC_W], rf_rd_data[31:PC_W]};

  assign pc_inc  = pc_q + PC_W'(1);
  assign addr_pc = PC_W'(imm_q[7:0]);
  assign is_jump = (op_q == OP_J) || (op_q == OP_JR) || (op_q == OP_JAL);

  // Next-PC resolution for the latched opcode, evaluated against the pre-update pc.
  always_comb begin
    pc_next = pc_inc;
    case (op_q)
      OP_BNE_BACK:          pc_next = (result_q != 32'd0) ? (pc_inc - imm_q) : pc_inc;
      OP_BNE_FWD:           pc_next = (result_q != 32'd0) ? (pc_inc + imm_q) : pc_inc;
      OP_BEQ_A, OP_BEQ_B:   pc_next = (result_q == 32'd0) ? (pc_inc + imm_q) : pc_inc;
      OP_BONE_A, OP_BONE_B: pc_next = (result_q == 32'd1) ? (pc_inc + imm_q) : pc_inc;
      OP_J:                 pc_next = addr_pc;
      OP_JR:                pc_next = rf_rd_data[PC_W-1:0];
      OP_JAL:               pc_next = addr_pc;
      default:              pc_next = pc_inc;
    endcase
  end

  // FSM transitions, instruction/result capture and the EXEC timeout counter.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    op_d     = op_q;
    reg0_d   = reg0_q;
    imm_d    = imm_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          op_d    = instr[31:26];
          reg0_d  = instr[25:21];
          imm_d   = instr[PC_W-1:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        cnt_d = '0;
        if (op_q == OP_HALT)  state_d = S_HALT;
        else if (is_jump)     state_d = S_RESOLVE;
        else                  state_d = S_EXEC;
      end
      S_EXEC: begin
        // alu_done is checked first so it wins over a simultaneous timeout.
        if (alu_done) begin
          result_d = alu_result;
          cnt_d    = '0;
          state_d  = S_RESOLVE;
        end else if (cnt_q == TO_W'(ALU_TIMEOUT - 1)) begin
          cnt_d   = cnt_q + TO_W'(1);
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_RESOLVE: begin
        pc_d    = pc_next;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state with synchronous reset; reset wins even mid-instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latched instruction fields and ALU result; only read after being written.
  always_ff @(posedge clk) begin
    op_q     <= op_d;
    reg0_q   <= reg0_d;
    imm_q    <= imm_d;
    result_q <= result_d;
  end

`ifdef PC_SEQ_PERF_CNT_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] instr_cnt_q, instr_cnt_d;

  // Saturating per-instruction and taken-transfer counters, stepped in RESOLVE.
  always_comb begin
    taken_cnt_d = taken_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (state_q == S_RESOLVE) begin
      if (instr_cnt_q != 16'hFFFF) instr_cnt_d = instr_cnt_q + 16'd1;
      if (((pc_next != pc_inc) || is_jump) && (taken_cnt_q != 16'hFFFF))
        taken_cnt_d = taken_cnt_q + 16'd1;
    end
  end

  // Counter registers cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign taken_cnt = taken_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

  // Outputs decoded from the current state; all are zero in IDLE after reset.
  always_comb begin
    imem_req  = (state_q == S_FETCH);
    alu_start = (state_q == S_EXEC) && (cnt_q == '0);
    link_we   = (state_q == S_RESOLVE) && (op_q == OP_JAL);
    link_data = link_we ? 32'(pc_inc) : 32'd0;
  end

  assign rf_rd_reg = reg0_q;
  assign pc        = pc_q;
  assign state_dbg = state_q;
  assign halted    = (state_q == S_HALT);
  assign error     = (state_q == S_ERROR);

endmodule
